// File: rtl/cic_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : cic_decimator_mc
// Purpose  : Multi-channel CIC decimator. N integrator stages run at the input
//            beat rate; every Reff beats the last integrator is captured and
//            pushed through N comb stages (differential delay M). The comb
//            result is rounded, right-shifted and saturated into the output.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            s_tdata/tvalid/tready - input samples, CHANNELS x WIDTH packed
//            m_tdata/tvalid/tready - output samples, CHANNELS x OUT_WIDTH
//            rate            - decimation rate R (0 -> 1, >RMAX -> RMAX)
//            shift           - output arithmetic right-shift (with rounding)
//            ovf             - sticky saturation flag
// Revision : 1.0 - initial release
// ============================================================================
module cic_decimator_mc #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 16,
  parameter int CHANNELS  = 2,
  parameter int RMAX      = 2048,
  parameter int M         = 1,
  parameter int N         = 3,
  parameter int REG_WIDTH = WIDTH + $clog2((64'(RMAX) * 64'(M)) ** N)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CHANNELS*WIDTH-1:0]       s_tdata,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  output logic [CHANNELS*OUT_WIDTH-1:0]   m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  input  logic [$clog2(RMAX+1)-1:0]       rate,
  input  logic [$clog2(REG_WIDTH)-1:0]    shift,
  output logic                            ovf
);

  localparam int c_rate_w  = $clog2(RMAX + 1);
  localparam int c_shift_w = $clog2(REG_WIDTH);
  // Registered comb stages: the last stage feeds the output register directly.
  localparam int c_nc      = (N > 1) ? N - 1 : 1;
  localparam logic signed [REG_WIDTH:0] c_out_max =
    (REG_WIDTH+1)'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [REG_WIDTH:0] c_out_min = -c_out_max - 1;

  logic [c_rate_w-1:0]             w_reff;
  logic [c_rate_w-1:0]             r_reff;
  logic [c_rate_w-1:0]             r_cnt;
  logic                            w_beat;
  logic                            w_dec;
  logic                            w_xfer;
  logic                            r_pend;
  logic                            r_mvalid;
  logic                            r_ovf;
  logic [CHANNELS*OUT_WIDTH-1:0]   r_mdata;
  logic [CHANNELS*OUT_WIDTH-1:0]   w_mdata;
  logic [CHANNELS-1:0]             w_sat;

  // Effective rate: 0 behaves as 1, anything above RMAX is clamped.
  always_comb begin
    w_reff = rate;
    if (rate == '0) begin
      w_reff = c_rate_w'(1);
    end else if (rate > c_rate_w'(RMAX)) begin
      w_reff = c_rate_w'(RMAX);
    end
  end

  // Input stalls only when a comb sample is waiting behind a stalled output.
  assign s_tready = rst | ~r_pend | ~r_mvalid | m_tready;
  assign w_beat   = s_tvalid & s_tready;
  assign w_dec    = w_beat & (r_cnt == r_reff - c_rate_w'(1));
  assign w_xfer   = r_pend & (~r_mvalid | m_tready);

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0]                    w_x;
      logic [N-1:0][REG_WIDTH-1:0]         r_int;
      logic [N-1:0][REG_WIDTH-1:0]         w_int_in;
      logic [REG_WIDTH-1:0]                r_cin;
      logic [c_nc-1:0][REG_WIDTH-1:0]      r_comb;
      logic [N-1:0][M-1:0][REG_WIDTH-1:0]  r_dly;
      logic [N-1:0][REG_WIDTH-1:0]         w_cin;
      logic [N-1:0][REG_WIDTH-1:0]         w_cout;
      logic signed [REG_WIDTH:0]           w_half;
      logic signed [REG_WIDTH:0]           w_sum;
      logic signed [REG_WIDTH:0]           w_scaled;
      logic                                w_hi;
      logic                                w_lo;
      logic [OUT_WIDTH-1:0]                w_y;

      assign w_x = s_tdata[c*WIDTH +: WIDTH];

      // Integrator k adds the pre-update value of stage k-1.
      always_comb begin
        w_int_in    = '0;
        w_int_in[0] = {{(REG_WIDTH-WIDTH){w_x[WIDTH-1]}}, w_x};
        for (int k = 1; k < N; k++) begin
          w_int_in[k] = r_int[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_int <= '0;
          r_cin <= '0;
        end else if (w_beat) begin
          for (int k = 0; k < N; k++) begin
            r_int[k] <= r_int[k] + w_int_in[k];
          end
          // Capture the post-update value of the last integrator.
          if (w_dec) begin
            r_cin <= r_int[N-1] + w_int_in[N-1];
          end
        end
      end

      // Comb stage k differences its registered input against the same input
      // M transfers earlier.
      always_comb begin
        w_cin    = '0;
        w_cout   = '0;
        w_cin[0] = r_cin;
        for (int k = 1; k < N; k++) begin
          w_cin[k] = r_comb[k-1];
        end
        for (int k = 0; k < N; k++) begin
          w_cout[k] = w_cin[k] - r_dly[k][M-1];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          r_comb <= '0;
          r_dly  <= '0;
        end else if (w_xfer) begin
          for (int k = 0; k < N - 1; k++) begin
            r_comb[k] <= w_cout[k];
          end
          for (int k = 0; k < N; k++) begin
            r_dly[k][0] <= w_cin[k];
            for (int i = 1; i < M; i++) begin
              r_dly[k][i] <= r_dly[k][i-1];
            end
          end
        end
      end

      // Round half up, arithmetic shift, then saturate. One extra bit keeps
      // the rounding add from wrapping.
      always_comb begin
        w_half = '0;
        if (shift != '0) begin
          w_half = (REG_WIDTH+1)'(1) << (shift - c_shift_w'(1));
        end
        w_sum    = $signed({w_cout[N-1][REG_WIDTH-1], w_cout[N-1]}) + w_half;
        w_scaled = w_sum >>> shift;
        w_hi     = (w_scaled > c_out_max);
        w_lo     = (w_scaled < c_out_min);
        if (w_hi) begin
          w_y = c_out_max[OUT_WIDTH-1:0];
        end else if (w_lo) begin
          w_y = c_out_min[OUT_WIDTH-1:0];
        end else begin
          w_y = w_scaled[OUT_WIDTH-1:0];
        end
      end

      assign w_sat[c]                          = w_hi | w_lo;
      assign w_mdata[c*OUT_WIDTH +: OUT_WIDTH] = w_y;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_reff   <= w_reff;
      r_pend   <= 1'b0;
      r_mvalid <= 1'b0;
      r_mdata  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      // New rate is picked up only at a frame boundary.
      if (w_beat) begin
        if (w_dec) begin
          r_cnt  <= '0;
          r_reff <= w_reff;
        end else begin
          r_cnt  <= r_cnt + c_rate_w'(1);
        end
      end

      if (w_dec) begin
        r_pend <= 1'b1;
      end else if (w_xfer) begin
        r_pend <= 1'b0;
      end

      if (w_xfer) begin
        r_mvalid <= 1'b1;
        r_mdata  <= w_mdata;
        if (|w_sat) begin
          r_ovf <= 1'b1;
        end
      end else if (m_tready) begin
        r_mvalid <= 1'b0;
      end
    end
  end

  assign m_tdata  = r_mdata;
  assign m_tvalid = r_mvalid;
  assign ovf      = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_cic_decimator_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_cic_decimator_mc
// Purpose  : Self-checking bench for cic_decimator_mc. Instance A uses default
//            parameters (directed DC, backpressure, rate change, saturation,
//            reset scenarios); instance B uses M=2, RMAX=16 under random
//            traffic. Outputs are compared to an arithmetic CIC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cic_decimator_mc;

  localparam int W    = 16;
  localparam int OW   = 16;
  localparam int CH   = 2;
  localparam int N    = 3;
  localparam int A_RW = 49;   // 16 + ceil(3*log2(2048*1))
  localparam int B_RW = 31;   // 16 + ceil(3*log2(16*2))
  localparam int DEPTH = 8192;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [CH*W-1:0]  a_sd, b_sd;
  logic             a_sv, b_sv, a_sr, b_sr;
  logic [CH*OW-1:0] a_md, b_md;
  logic             a_mv, b_mv, a_mr, b_mr;
  logic [11:0]      a_rate;
  logic [4:0]       b_rate;
  logic [5:0]       a_shift;
  logic [4:0]       b_shift;
  logic             a_ovf, b_ovf;

  cic_decimator_mc dut_a (
    .clk(clk), .rst(rst), .s_tdata(a_sd), .s_tvalid(a_sv), .s_tready(a_sr),
    .m_tdata(a_md), .m_tvalid(a_mv), .m_tready(a_mr), .rate(a_rate),
    .shift(a_shift), .ovf(a_ovf));

  cic_decimator_mc #(.RMAX(16), .M(2)) dut_b (
    .clk(clk), .rst(rst), .s_tdata(b_sd), .s_tvalid(b_sv), .s_tready(b_sr),
    .m_tdata(b_md), .m_tvalid(b_mv), .m_tready(b_mr), .rate(b_rate),
    .shift(b_shift), .ovf(b_ovf));

  // ---------------- reference model ----------------
  longint           acc [2][CH][N];
  longint           vh  [2][CH][DEPTH];
  logic [CH*OW-1:0] exq [2][DEPTH];
  int nv[2], exr[2], mcnt[2], mreff[2];

  int ncmp = 0, nfail = 0, cyc = 0;
  int a_outs, a_first, a_gap, a_last_cyc;
  logic [CH*OW-1:0] a_last;

  function automatic int rw_of(int d);   return (d == 0) ? A_RW : B_RW; endfunction
  function automatic int m_of(int d);    return (d == 0) ? 1 : 2; endfunction
  function automatic int rmax_of(int d); return (d == 0) ? 2048 : 16; endfunction
  function automatic int clampr(int d, int r);
    if (r == 0) return 1;
    if (r > rmax_of(d)) return rmax_of(d);
    return r;
  endfunction
  function automatic longint wrapm(longint v, int rw);
    return v & ((64'sd1 <<< rw) - 64'sd1);
  endfunction
  function automatic longint sgn(longint v, int rw);
    longint u = wrapm(v, rw);
    if (u >= (64'sd1 <<< (rw - 1))) return u - (64'sd1 <<< rw);
    return u;
  endfunction
  function automatic longint coef(int i);   // (1 - z^-M)^3 binomial taps
    case (i)
      0: return 1;
      1: return -3;
      2: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset(int d, int r);
    for (int c = 0; c < CH; c++) for (int k = 0; k < N; k++) acc[d][c][k] = 0;
    nv[d] = 0; exr[d] = 0; mcnt[d] = 0; mreff[d] = clampr(d, r);
  endtask

  // Output j is the 3rd-order M-difference of the decimated integrator
  // sequence, delayed by N-1 outputs, then rounded/shifted/saturated.
  task automatic decimate(int d, int sh);
    int j = nv[d];
    logic [CH*OW-1:0] e;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      longint dd = 0, y;
      vh[d][c][j] = acc[d][c][N-1];
      for (int i = 0; i <= N; i++) begin
        int idx = j - (N - 1) - i * m_of(d);
        if (idx >= 0) dd += coef(i) * vh[d][c][idx];
      end
      dd = sgn(dd, rw_of(d));
      y  = (sh == 0) ? dd : ((dd + (64'sd1 <<< (sh - 1))) >>> sh);
      if (y > 32767) y = 32767;
      else if (y < -32768) y = -32768;
      e[c*OW +: OW] = y[15:0];
    end
    exq[d][j] = e;
    if (nv[d] < DEPTH - 1) nv[d]++;
  endtask

  task automatic model_beat(int d, logic [CH*W-1:0] sd, int r, int sh);
    for (int c = 0; c < CH; c++) begin
      longint x  = longint'($signed(sd[c*W +: W]));
      longint o0 = acc[d][c][0], o1 = acc[d][c][1];
      acc[d][c][0] = wrapm(o0 + x, rw_of(d));
      acc[d][c][1] = wrapm(acc[d][c][1] + o0, rw_of(d));
      acc[d][c][2] = wrapm(acc[d][c][2] + o1, rw_of(d));
    end
    if (mcnt[d] == mreff[d] - 1) begin
      decimate(d, sh);
      mcnt[d] = 0;
      mreff[d] = clampr(d, r);
    end else begin
      mcnt[d]++;
    end
  endtask

  task automatic got_out(int d, logic [CH*OW-1:0] data);
    if (exr[d] < nv[d]) begin
      check($sformatf("dut%0d out#%0d", d, exr[d]), data, exq[d][exr[d]]);
      exr[d]++;
    end else begin
      ncmp++; nfail++;
      $error("FAIL dut%0d unexpected output: observed %0h, expected none", d, data);
    end
  endtask

  // One clock: observe handshakes at negedge, then advance past posedge.
  task automatic step();
    @(negedge clk);
    if (rst) begin
      model_reset(0, a_rate); model_reset(1, b_rate);
      a_outs = 0; a_gap = 0; a_first = -1;
    end else begin
      if (a_sv && a_sr) model_beat(0, a_sd, a_rate, a_shift);
      if (b_sv && b_sr) model_beat(1, b_sd, b_rate, b_shift);
      if (a_mv && a_mr) begin
        got_out(0, a_md);
        a_outs++;
        if (a_outs == 1) a_first = cyc; else a_gap = cyc - a_last_cyc;
        a_last_cyc = cyc;
        a_last = a_md;
      end
      if (b_mv && b_mr) got_out(1, b_md);
    end
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic reset_a(int r);
    rst = 1'b1; a_rate = 12'(r); step(); rst = 1'b0; cyc = 0;
  endtask

  task automatic wait_a_outs(string tag, int target, int budget);
    int n = 0;
    while (a_outs < target && n < budget) begin step(); n++; end
    check(tag, a_outs >= target, 1);
  endtask

  localparam logic [CH*W-1:0] DC = {16'hFFFF, 16'h0001};
  logic [CH*OW-1:0] hold;
  int n;

  initial begin
    rst = 1'b1; a_sv = 1'b1; b_sv = 1'b0; a_mr = 1'b1; b_mr = 1'b1;
    a_rate = 12'd4; b_rate = 5'd4; a_shift = '0; b_shift = '0;
    a_sd = DC; b_sd = '0;
    repeat (3) step();
    check("reset s_tready", a_sr, 1);
    check("reset m_tvalid", a_mv, 0);
    check("reset m_tdata", a_md, 0);
    check("reset ovf", a_ovf, 0);
    check("reset b m_tvalid", b_mv, 0);

    // DC gain R^N = 64
    rst = 1'b0; cyc = 0;
    repeat (40) step();
    check("dc ch0", $signed(a_last[15:0]), 64);
    check("dc ch1", $signed(a_last[31:16]), -64);
    check("dc gap", a_gap, 4);
    check("dc latency", a_first, 5);
    check("dc ovf", a_ovf, 0);

    // Backpressure at rate 1
    reset_a(1);
    a_mr = 1'b0;
    a_sd = $urandom; step();
    a_sd = $urandom; step();
    check("bp s_tready low", a_sr, 0);
    hold = a_md;
    repeat (10) begin a_sd = $urandom; step(); end
    check("bp data stable", a_md, hold);
    check("bp valid held", a_mv, 1);
    check("bp still stalled", a_sr, 0);
    a_mr = 1'b1;
    repeat (6) begin a_sd = $urandom; step(); end
    a_sv = 1'b0;
    repeat (6) step();
    check("bp output count", a_outs, 8);
    check("bp drained", exr[0], nv[0]);

    // Rate change 8 -> 2 mid-frame, then rate 0
    reset_a(8);
    a_sv = 1'b1; a_sd = DC;
    repeat (3) step();
    a_rate = 12'd2;
    repeat (14) step();
    check("rate first frame latency", a_first, 9);
    check("rate new gap", a_gap, 2);
    a_rate = 12'd0;
    repeat (8) step();
    check("rate zero gap", a_gap, 1);

    // Saturation
    reset_a(2048);
    a_sd = {16'h0000, 16'h7FFF};
    wait_a_outs("sat reached", 6, 6 * 2048 + 100);
    check("sat ch0", $signed(a_last[15:0]), 32767);
    check("sat ovf", a_ovf, 1);
    a_shift = 6'd33;
    wait_a_outs("sat shift reached", 9, 3 * 2048 + 100);
    check("sat shift33 ch0", $signed(a_last[15:0]), 32767);
    check("sat ovf sticky", a_ovf, 1);

    // Reset while output stalled
    a_mr = 1'b0;
    n = 0;
    while (!a_mv && n < 4200) begin step(); n++; end
    check("pre-reset valid", a_mv, 1);
    a_shift = '0; a_sd = DC;
    reset_a(4);
    check("post-reset valid", a_mv, 0);
    check("post-reset ovf", a_ovf, 0);
    a_mr = 1'b1;
    repeat (30) step();
    check("restart ch0", $signed(a_last[15:0]), 64);
    check("restart ch1", $signed(a_last[31:16]), -64);
    check("restart latency", a_first, 5);
    a_sv = 1'b0;

    // Random traffic on M=2 instance
    for (int seg = 0; seg < 3; seg++) begin
      rst = 1'b1;
      b_shift = (seg == 0) ? 5'd0 : 5'($urandom_range(1, 30));
      b_rate  = 5'($urandom_range(0, 31));
      step();
      rst = 1'b0;
      repeat (1500) begin
        b_sv = ($urandom_range(0, 9) < 7);
        b_mr = ($urandom_range(0, 9) < 7);
        b_sd = $urandom;
        if ($urandom_range(0, 99) == 0) b_rate = 5'($urandom_range(0, 31));
        step();
      end
      b_sv = 1'b0; b_mr = 1'b1;
      repeat (40) step();
      check($sformatf("rand seg%0d drained", seg), exr[1], nv[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cic_decimator_mc.md
CIC_DECIMATOR_MC -- requirements
Module: cic_decimator_mc

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the signed input sample width per channel.
REQ-002 The block SHALL have parameter OUT_WIDTH, default 16, meaning the signed output sample width per channel.
REQ-003 The block SHALL have parameter CHANNELS, default 2, meaning the number of lock-step channels.
REQ-004 The block SHALL have parameter RMAX, default 2048, meaning the maximum decimation rate.
REQ-005 The block SHALL have parameter M, default 1, meaning the comb differential delay.
REQ-006 The block SHALL have parameter N, default 3, meaning the number of integrator and comb stages.
REQ-007 The block SHALL have derived parameter REG_WIDTH, equal to WIDTH + ceil(N*log2(RMAX*M)), default 49, meaning the internal register width.
REQ-008 Ports SHALL be, in order:
- clk  in  1  clock.
- rst  in  1  reset.
- s_tdata  in  CHANNELS*WIDTH  input samples; channel c occupies bits [c*WIDTH +: WIDTH].
- s_tvalid  in  1  input valid.
- s_tready  out  1  input ready.
- m_tdata  out  CHANNELS*OUT_WIDTH  output samples, same packing.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- rate  in  clog2(RMAX+1)  decimation rate R.
- shift  in  clog2(REG_WIDTH)  output right-shift.
- ovf  out  1  sticky saturation flag.
REQ-009 Reset SHALL be rst, synchronous, active-high, and the clock SHALL be clk.

Function
REQ-010 An input beat SHALL be s_tvalid && s_tready, and all channels SHALL advance together on each beat.
REQ-011 On each input beat, integrator k of each channel SHALL add its input (the sign-extended sample for k=0, the pre-update integrator k-1 for k>0), wrapping modulo 2^REG_WIDTH.
REQ-012 A decimation counter SHALL count input beats from 0 to Reff-1 and then wrap to 0.
- Reff is rate clamped to the range 1..RMAX; rate 0 is treated as 1.
- The beat on which the counter equals Reff-1 is the decimation beat.
REQ-013 Reff SHALL be latched only when the counter wraps, and at reset; a rate change mid-frame SHALL take effect from the next frame.
REQ-014 On a decimation beat, the post-update value of integrator N-1 SHALL be captured per channel into the comb input, and comb_pend SHALL be set.
REQ-015 The comb chain SHALL update only when a pending sample transfers to the output register.
- Comb k output = comb input minus that input delayed by M transfers, using registered stage values.
- Group delay is therefore N-1 decimated samples.
REQ-016 A transfer SHALL occur when comb_pend && (!m_tvalid || m_tready).
- On transfer, m_tdata loads the scaled comb N-1 values and m_tvalid is set.
- comb_pend is cleared unless a new decimation beat occurs in the same cycle.
REQ-017 m_tvalid SHALL clear on m_tvalid && m_tready when no transfer occurs in that cycle, and m_tdata SHALL stay stable while m_tvalid && !m_tready.
REQ-018 s_tready SHALL equal !comb_pend || !m_tvalid || m_tready, giving one input beat per clk with no bubbles while m_tready=1.
REQ-019 Scaling SHALL compute (comb + 2^(shift-1)) >>> shift (arithmetic shift; no rounding when shift=0) and saturate to the signed OUT_WIDTH range.
REQ-020 ovf SHALL set on any transfer in which any channel saturates, and SHALL be cleared only by rst.
REQ-021 Latency from decimation beat to m_tvalid SHALL be 2 clk when the output register is free.

Reset
REQ-022 While rst=1, the block SHALL clear all integrators, comb and delay registers, the counter, comb_pend, m_tvalid, m_tdata and ovf to 0, and SHALL latch Reff.
REQ-023 While rst=1, s_tready SHALL be 1 and no input beat SHALL alter state.
REQ-024 Asserting rst mid-frame or with an output stalled SHALL discard all in-flight data, with no m_tvalid in the cycle after rst deasserts.

Verification
REQ-025 DC: ch0=1, ch1=-1, rate=4, shift=0, m_tready=1 -> steady m_tdata ch0=64, ch1=-64; one m_tvalid every 4 beats; ovf=0.
REQ-026 Backpressure: rate=1, m_tready held 0 for 10 cycles -> s_tready=0 after two beats; m_tdata stable; no sample lost or duplicated on release.
REQ-027 Saturation: ch0=32767, rate=2048, shift=0 -> output 32767, ovf=1 and stays 1; with shift=33 output is approximately 32767, the ovf state from earlier is retained.
REQ-028 Rate change: rate changed 8->2 mid-frame -> current frame completes at 8 beats, subsequent outputs every 2 beats; rate=0 behaves as 1.
REQ-029 Reset mid-operation: rst for 1 cycle while m_tvalid=1 and m_tready=0 -> m_tvalid=0, ovf=0, and DC response restarts from the zero state.
REQ-030 Random: random CHANNELS data and random valid/ready, with N=3, M=2 -> m_tdata matches a bit-true integer reference model, per channel.
